// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - 8N1 (optionally 8E1) UART receiver with first-word-fall-through receive FIFO
//
// Optional feature macro: UART_MON_PARITY_EN (inserts an even-parity bit between data and stop).
//
// Ports:
//   clk          in   SoC clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx_i         in   serial line, idle high, asynchronous to clk
//   clr_i        in   synchronous clear of FIFO and sticky flags
//   rd_en_i      in   pop head entry when rd_valid_o is high
//   rd_data_o    out  FIFO head (8'h00 while empty)
//   rd_valid_o   out  FIFO not empty
//   fifo_count_o out  occupied entries
//   rx_busy_o    out  receiver FSM not idle
//   frame_err_o  out  sticky: stop bit sampled low
//   overflow_o   out  sticky: byte dropped on full FIFO
//   parity_err_o out  sticky: parity mismatch (constant 0 without the macro)

module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    input  logic                          clr_i,
    input  logic                          rd_en_i,
    output logic [7:0]                    rd_data_o,
    output logic                          rd_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          rx_busy_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic                          parity_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_MON_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [7:0]      byte_q;
    logic            push_q;
    logic            ferr_q;
    logic            half_hit;
    logic            bit_hit;
    logic            cnt_run;
    logic            data_smp;
    logic            stop_smp;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign half_hit = (cnt == HALF_M1);
    assign bit_hit  = (cnt == FULL_M1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: if (half_hit) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (bit_hit && bit_idx == 3'd7) begin
`ifdef UART_MON_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_MON_PARITY_EN
            S_PARITY: if (bit_hit) state_d = S_STOP;
`endif
            S_STOP:  if (bit_hit) state_d = rx_s ? S_IDLE : S_WAIT;
            S_WAIT:  if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        rx_busy_o = (state_q != S_IDLE);
        cnt_run   = 1'b0;
        data_smp  = 1'b0;
        stop_smp  = 1'b0;
        case (state_q)
            S_START:  cnt_run = 1'b1;
            S_DATA: begin
                cnt_run  = 1'b1;
                data_smp = bit_hit;
            end
`ifdef UART_MON_PARITY_EN
            S_PARITY: cnt_run = 1'b1;
`endif
            S_STOP: begin
                cnt_run  = 1'b1;
                stop_smp = bit_hit;
            end
            default: cnt_run = 1'b0;
        endcase
    end

    // Bit timing counter restarts on every state change and after every data sample,
    // so each sample lands one full bit period after the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            byte_q  <= 8'h00;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (state_d != state_q || data_smp) begin
                cnt <= '0;
            end else if (cnt_run) begin
                cnt <= cnt + CW'(1);
            end
            if (state_q == S_START) begin
                bit_idx <= 3'd0;
            end else if (data_smp) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (data_smp) begin
                shreg <= {rx_s, shreg[7:1]};
            end
            if (stop_smp) begin
                byte_q <= shreg;
            end
            push_q <= stop_smp & rx_s;
            ferr_q <= stop_smp & ~rx_s;
        end
    end

`ifdef UART_MON_PARITY_EN
    logic perr_q;

    // Even parity: data bits XOR parity bit must be zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= (state_q == S_PARITY) && bit_hit && (rx_s ^ (^shreg));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_o <= 1'b0;
        end else if (clr_i) begin
            parity_err_o <= 1'b0;
        end else if (perr_q) begin
            parity_err_o <= 1'b1;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

    // Receive FIFO: occupancy kept in its own counter so full and empty never alias.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == NW'(FIFO_DEPTH));
    assign pop     = rd_en_i & ~empty & ~clr_i;
    // A pop on the same edge frees the slot the incoming byte needs.
    assign push_ok = push_q & ~clr_i & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else if (clr_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + NW'(1);
            end else if (pop && !push_ok) begin
                count <= count - NW'(1);
            end
            if (push_q && full && !pop) begin
                overflow_o <= 1'b1;
            end
            if (ferr_q) begin
                frame_err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= byte_q;
        end
    end

    assign rd_data_o    = empty ? 8'h00 : mem[rd_ptr];
    assign rd_valid_o   = ~empty;
    assign fifo_count_o = count;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - self-checking bench for uart_rx_monitor

module tb_uart_rx_monitor;

    localparam int C = 32;
    localparam int D = 16;
`ifdef UART_MON_PARITY_EN
    localparam int LAT = 3 + C / 2 + 10 * C;
`else
    localparam int LAT = 3 + C / 2 + 9 * C;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       clr_i = 1'b0;
    logic       rd_en_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic [4:0] fifo_count_o;
    logic       rx_busy_o;
    logic       frame_err_o;
    logic       overflow_o;
    logic       parity_err_o;

    int total = 0;
    int bad = 0;

    // Reference model: expected FIFO contents and sticky flags
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_perr = 1'b0;

    uart_rx_monitor #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .clr_i        (clr_i),
        .rd_en_i      (rd_en_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .fifo_count_o (fifo_count_o),
        .rx_busy_o    (rx_busy_o),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    task automatic model_rx(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        if (!stop_ok) begin
            exp_ferr = 1'b1;
        end else begin
`ifdef UART_MON_PARITY_EN
            if (!par_ok) exp_perr = 1'b1;
`endif
            if (exp_q.size() < D) exp_q.push_back(d);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
    endtask

    // Called at posedge+1; each bit is held for exactly C clock edges.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
        rx_i = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (C) @(posedge clk);
            #1;
        end
`ifdef UART_MON_PARITY_EN
        rx_i = (^d) ^ ~par_ok;
        repeat (C) @(posedge clk);
        #1;
`endif
        rx_i = stop_bit;
        repeat (C) @(posedge clk);
        #1;
        rx_i = 1'b1;
    endtask

    task automatic pop_byte(output logic [7:0] d);
        d = rd_data_o;
        rd_en_i = 1'b1;
        @(posedge clk);
        #1;
        rd_en_i = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total += 6;
        if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", rd_valid_o); end
        if (fifo_count_o !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
        if (rd_data_o !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", rd_data_o); end
        if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", rx_busy_o); end
        if ({frame_err_o, overflow_o} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %0b want 0", {frame_err_o, overflow_o}); end
        if (parity_err_o !== 1'b0) begin bad++; $display("FAIL reset_perr: got %0b want 0", parity_err_o); end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        fork
            send_frame(8'h65, 1'b1, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                #2;
                total++;
                if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL latency_early: valid=%0b want 0 at cycle %0d", rd_valid_o, LAT - 1); end
                @(posedge clk);
                #2;
                total++;
                if (rd_valid_o !== 1'b1) begin bad++; $display("FAIL latency_on_time: valid=%0b want 1 at cycle %0d", rd_valid_o, LAT); end
            end
        join
        model_rx(8'h65, 1'b1, 1'b1);
        total += 2;
        if (fifo_count_o !== 5'd1) begin bad++; $display("FAIL single_count: got %0d want 1", fifo_count_o); end
        if (rd_data_o !== 8'h65) begin bad++; $display("FAIL single_data: got %0h want 65", rd_data_o); end
        pop_byte(d);
        void'(exp_q.pop_front());
        total++;
        if (fifo_count_o !== 5'd0) begin bad++; $display("FAIL single_pop_count: got %0d want 0", fifo_count_o); end
    endtask

    task automatic test_glitch();
        rx_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (rx_busy_o !== 1'b1) begin bad++; $display("FAIL glitch_busy: got %0b want 1", rx_busy_o); end
        repeat (5) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (2 * C) @(posedge clk);
        #1;
        total += 3;
        if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL glitch_idle: got %0b want 0", rx_busy_o); end
        if (fifo_count_o !== 5'd0) begin bad++; $display("FAIL glitch_count: got %0d want 0", fifo_count_o); end
        if ({frame_err_o, overflow_o} !== 2'b00) begin bad++; $display("FAIL glitch_flags: got %0b want 0", {frame_err_o, overflow_o}); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h38, 1'b0, 1'b1);
        model_rx(8'h38, 1'b0, 1'b1);
        repeat (C) @(posedge clk);
        #1;
        total += 2;
        if (frame_err_o !== exp_ferr) begin bad++; $display("FAIL ferr_flag: got %0b want %0b", frame_err_o, exp_ferr); end
        if (fifo_count_o !== 5'(exp_q.size())) begin bad++; $display("FAIL ferr_count: got %0d want %0d", fifo_count_o, exp_q.size()); end
        send_frame(8'h41, 1'b1, 1'b1);
        model_rx(8'h41, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        total += 2;
        if (rd_data_o !== exp_q[0]) begin bad++; $display("FAIL ferr_next_data: got %0h want %0h", rd_data_o, exp_q[0]); end
        if (frame_err_o !== exp_ferr) begin bad++; $display("FAIL ferr_sticky: got %0b want %0b", frame_err_o, exp_ferr); end
    endtask

    task automatic test_clear();
        pulse_clr();
        total += 4;
        if (fifo_count_o !== 5'd0) begin bad++; $display("FAIL clr_count: got %0d want 0", fifo_count_o); end
        if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL clr_valid: got %0b want 0", rd_valid_o); end
        if (rd_data_o !== 8'h00) begin bad++; $display("FAIL clr_data: got %0h want 0", rd_data_o); end
        if ({frame_err_o, overflow_o, parity_err_o} !== 3'b000) begin bad++; $display("FAIL clr_flags: got %0b want 0", {frame_err_o, overflow_o, parity_err_o}); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic [7:0] e;
        pulse_clr();
        for (int i = 0; i <= D; i++) begin
            send_frame(8'(i), 1'b1, 1'b1);
            model_rx(8'(i), 1'b1, 1'b1);
        end
        repeat (4) @(posedge clk);
        #1;
        total += 2;
        if (fifo_count_o !== 5'(exp_q.size())) begin bad++; $display("FAIL ovf_count: got %0d want %0d", fifo_count_o, exp_q.size()); end
        if (overflow_o !== exp_ovf) begin bad++; $display("FAIL ovf_flag: got %0b want %0b", overflow_o, exp_ovf); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_byte(d);
            total++;
            if (d !== e) begin bad++; $display("FAIL ovf_order: got %0h want %0h", d, e); end
        end
        total++;
        if (fifo_count_o !== 5'd0) begin bad++; $display("FAIL ovf_drain: got %0d want 0", fifo_count_o); end
    endtask

    task automatic test_pop_on_full();
        logic [7:0] d;
        logic [7:0] e;
        logic [7:0] nb;
        pulse_clr();
        for (int i = 0; i < D; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'b1);
            model_rx(d, 1'b1, 1'b1);
        end
        nb = 8'($urandom);
        fork
            send_frame(nb, 1'b1, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                #1;
                total++;
                if (rd_data_o !== exp_q[0]) begin bad++; $display("FAIL pof_head: got %0h want %0h", rd_data_o, exp_q[0]); end
                rd_en_i = 1'b1;
                @(posedge clk);
                #1;
                rd_en_i = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        model_rx(nb, 1'b1, 1'b1);
        total += 2;
        if (fifo_count_o !== 5'(exp_q.size())) begin bad++; $display("FAIL pof_count: got %0d want %0d", fifo_count_o, exp_q.size()); end
        if (overflow_o !== exp_ovf) begin bad++; $display("FAIL pof_ovf: got %0b want %0b", overflow_o, exp_ovf); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_byte(d);
            total++;
            if (d !== e) begin bad++; $display("FAIL pof_order: got %0h want %0h", d, e); end
        end
    endtask

    task automatic test_reset_mid();
        rx_i = 1'b0;
        repeat (3 * C) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_i = 1'b1;
        model_clear();
        #2;
        total++;
        if (rx_busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %0b want 0", rx_busy_o); end
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2 * C) @(posedge clk);
        #1;
        send_frame(8'h55, 1'b1, 1'b1);
        model_rx(8'h55, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        total += 3;
        if (fifo_count_o !== 5'(exp_q.size())) begin bad++; $display("FAIL rstmid_count: got %0d want %0d", fifo_count_o, exp_q.size()); end
        if (rd_data_o !== exp_q[0]) begin bad++; $display("FAIL rstmid_data: got %0h want %0h", rd_data_o, exp_q[0]); end
        if (frame_err_o !== exp_ferr) begin bad++; $display("FAIL rstmid_ferr: got %0b want %0b", frame_err_o, exp_ferr); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] e;
        logic       stop_ok;
        int         n;
        pulse_clr();
        n = $urandom_range(5, 8);
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_ok, 1'b1);
            model_rx(d, stop_ok, 1'b1);
            // After a bad stop the line must go idle before the next start can be seen.
            if (stop_ok) repeat ($urandom_range(0, 20)) @(posedge clk);
            else repeat (C + $urandom_range(0, 20)) @(posedge clk);
            #1;
        end
        repeat (4) @(posedge clk);
        #1;
        total += 4;
        if (fifo_count_o !== 5'(exp_q.size())) begin bad++; $display("FAIL rand_count: got %0d want %0d", fifo_count_o, exp_q.size()); end
        if (frame_err_o !== exp_ferr) begin bad++; $display("FAIL rand_ferr: got %0b want %0b", frame_err_o, exp_ferr); end
        if (overflow_o !== exp_ovf) begin bad++; $display("FAIL rand_ovf: got %0b want %0b", overflow_o, exp_ovf); end
        if (parity_err_o !== exp_perr) begin bad++; $display("FAIL rand_perr: got %0b want %0b", parity_err_o, exp_perr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_byte(d);
            total++;
            if (d !== e) begin bad++; $display("FAIL rand_data: got %0h want %0h", d, e); end
        end
    endtask

`ifdef UART_MON_PARITY_EN
    task automatic test_parity();
        pulse_clr();
        send_frame(8'h07, 1'b1, 1'b0);
        model_rx(8'h07, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        total += 3;
        if (parity_err_o !== exp_perr) begin bad++; $display("FAIL par_flag: got %0b want %0b", parity_err_o, exp_perr); end
        if (fifo_count_o !== 5'(exp_q.size())) begin bad++; $display("FAIL par_count: got %0d want %0d", fifo_count_o, exp_q.size()); end
        if (rd_data_o !== exp_q[0]) begin bad++; $display("FAIL par_data: got %0h want %0h", rd_data_o, exp_q[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_clear();
        test_overflow();
        test_pop_on_full();
        test_reset_mid();
        test_random();
`ifdef UART_MON_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
